uart_tx_param: RTL and testbench

Parametrised successor to the fixed 8N1 serial transmitter. It adds an internal baud divider, configurable data width, parity and stop bits, and a ready/valid handshake with a per-frame done pulse. It sits between the music/control logic and the board TX pin, and serialises words LSB first.

---
 rtl/uart_tx_param.sv | 178 +++++++++++++++++
 tb/tb_uart_tx_param.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
// uart_tx_param : parametrised UART transmitter (LSB first, ready/valid in,
//                 per-frame done pulse). Define UART_TX_FIFO_EN for a word buffer.
// Revision      : 1.0 - initial release
// ============================================================================
module uart_tx_param #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int CLK_DIV    = 5208,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_en,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_busy,
  output logic                 tx_stop,
  output logic                 tx_out
);
  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam int BIT_W  = 4;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("uart_tx_param: CLK_DIV must be >= 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PAR_BIT = 3'd3,
    STOP    = 3'd4
  } state_t;

  state_t               state, state_nx;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 baud_tick;
  logic                 frame_end;
  logic                 launch;
  logic [DATA_BITS-1:0] launch_word;

  assign baud_tick = (baud_cnt == BAUD_LAST);
  assign frame_end = (state == STOP) && baud_tick && (bit_cnt == STOP_LAST);
  assign tx_busy   = (state != IDLE);

`ifdef UART_TX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // The word on the line keeps its slot until its frame ends, so the slot
  // is released (pop) on the same edge that launches the next queued word.
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     rd_ptr, wr_ptr;
  logic [CNT_W-1:0]     count;
  logic                 full, push;

  assign full        = (count == CNT_W'(FIFO_DEPTH));
  assign tx_ready    = !full || frame_end;
  assign push        = tx_en && tx_ready;
  assign launch      = ((state == IDLE) && (count != '0)) ||
                       (frame_end && (count >= CNT_W'(2)));
  assign launch_word = (state == IDLE) ? mem[rd_ptr] : mem[PTR_W'(rd_ptr + 1'b1)];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (frame_end) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(push) - CNT_W'(frame_end);
    end
  end
`else
  assign tx_ready    = (state == IDLE) || frame_end;
  assign launch      = tx_en && tx_ready;
  assign launch_word = tx_data;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (launch) state_nx = START;
      START:   if (baud_tick) state_nx = DATA;
      DATA:    if (baud_tick && bit_cnt == DATA_LAST)
                 state_nx = (PARITY != 0) ? PAR_BIT : STOP;
      PAR_BIT: if (baud_tick) state_nx = STOP;
      STOP:    if (frame_end) state_nx = launch ? START : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      tx_out   <= 1'b1;
      tx_stop  <= 1'b0;
    end else begin
      state   <= state_nx;
      tx_stop <= frame_end;
      if (launch) begin
        baud_cnt <= '0;
        bit_cnt  <= '0;
        shreg    <= launch_word;
        par_bit  <= (PARITY == 1) ? ~^launch_word : ^launch_word;
        tx_out   <= 1'b0;
      end else if (state != IDLE) begin
        if (!baud_tick) begin
          baud_cnt <= baud_cnt + 1'b1;
        end else begin
          baud_cnt <= '0;
          case (state)
            START: begin
              bit_cnt <= '0;
              tx_out  <= shreg[0];
            end
            DATA: begin
              if (bit_cnt == DATA_LAST) begin
                bit_cnt <= '0;
                tx_out  <= (PARITY != 0) ? par_bit : 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                shreg   <= shreg >> 1;
                tx_out  <= shreg[1];
              end
            end
            PAR_BIT: begin
              bit_cnt <= '0;
              tx_out  <= 1'b1;
            end
            STOP: begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_out  <= 1'b1;
            end
            default: tx_out <= 1'b1;
          endcase
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_param.sv
`default_nettype none
// Scoreboard bench for uart_tx_param: four parameter sets share one driver;
// a negedge monitor decodes tx_out and compares against queued frames.
module tb_uart_tx_param;
  localparam int CDIV = 4;
`ifdef UART_TX_FIFO_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  typedef struct {
    logic [15:0] bits;
    int          n;
    int          launch;
    int          id;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_en = 1'b0;
  logic [7:0] data = 8'h00;
  logic [1:0] sel = 2'd0;
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         next_id = 0;

  logic [3:0] en_v, out_v, busy_v, stop_v, ready_v;
  logic       m_out, m_busy, m_stop;

  exp_t       exp_q[$];
  exp_t       cur;
  bit         active = 1'b0;
  bit         stop_due = 1'b0;
  int         k = 0;
  logic [3:0] samp_o, samp_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign en_v   = tx_en ? (4'b0001 << sel) : 4'b0000;
  assign m_out  = out_v[sel];
  assign m_busy = busy_v[sel];
  assign m_stop = stop_v[sel];

  uart_tx_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLK_DIV(CDIV), .FIFO_DEPTH(4)) u_d0 (
    .clk(clk), .rst(rst), .tx_en(en_v[0]), .tx_data(data),
    .tx_ready(ready_v[0]), .tx_busy(busy_v[0]), .tx_stop(stop_v[0]), .tx_out(out_v[0]));
  uart_tx_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .CLK_DIV(CDIV), .FIFO_DEPTH(4)) u_d1 (
    .clk(clk), .rst(rst), .tx_en(en_v[1]), .tx_data(data),
    .tx_ready(ready_v[1]), .tx_busy(busy_v[1]), .tx_stop(stop_v[1]), .tx_out(out_v[1]));
  uart_tx_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .CLK_DIV(CDIV), .FIFO_DEPTH(4)) u_d2 (
    .clk(clk), .rst(rst), .tx_en(en_v[2]), .tx_data(data),
    .tx_ready(ready_v[2]), .tx_busy(busy_v[2]), .tx_stop(stop_v[2]), .tx_out(out_v[2]));
  uart_tx_param #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .CLK_DIV(CDIV), .FIFO_DEPTH(4)) u_d3 (
    .clk(clk), .rst(rst), .tx_en(en_v[3]), .tx_data(data[6:0]),
    .tx_ready(ready_v[3]), .tx_busy(busy_v[3]), .tx_stop(stop_v[3]), .tx_out(out_v[3]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Frame strings list line levels in time order: start, data LSB first, parity, stop.
  task automatic expect_frame(input string f, input int launch);
    exp_t e;
    e.bits = '0;
    for (int i = 0; i < f.len(); i++) e.bits[i] = (f.getc(i) == 8'h31);
    e.n      = f.len();
    e.launch = launch;
    e.id     = next_id++;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [1:0] d, input logic [7:0] w, input string f, input int wait_cyc);
    sel   = d;
    data  = w;
    tx_en = 1'b1;
    expect_frame(f, cyc + 1 + LAT);
    @(negedge clk);
    tx_en = 1'b0;
    data  = ~w;
    repeat (wait_cyc) @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " busy"},  m_busy, 1'b0);
    check({tag, " ready"}, ready_v[sel], 1'b1);
    check({tag, " line"},  m_out, 1'b1);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      active   = 1'b0;
      stop_due = 1'b0;
    end else begin
      check("tx_stop", m_stop, stop_due);
      stop_due = 1'b0;
      if (!active) begin
        if (exp_q.size() == 0) begin
          check("idle_line", m_out, 1'b1);
        end else if (m_out == 1'b0) begin
          cur = exp_q.pop_front();
          check($sformatf("frame%0d launch_cycle", cur.id), cyc, cur.launch);
          active = 1'b1;
          k      = 0;
        end
      end
      if (active) begin
        samp_o[k % CDIV] = m_out;
        samp_b[k % CDIV] = m_busy;
        if (k % CDIV == CDIV - 1) begin
          check($sformatf("frame%0d bit%0d line", cur.id, k / CDIV), samp_o, {4{cur.bits[k / CDIV]}});
          check($sformatf("frame%0d bit%0d busy", cur.id, k / CDIV), samp_b, 4'hF);
        end
        k++;
        if (k == cur.n * CDIV) begin
          active   = 1'b0;
          stop_due = 1'b1;
        end
      end
    end
  end

  initial begin
    int t;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset d%0d line", i),  out_v[i],   1'b1);
      check($sformatf("reset d%0d busy", i),  busy_v[i],  1'b0);
      check($sformatf("reset d%0d ready", i), ready_v[i], 1'b1);
      check($sformatf("reset d%0d stop", i),  stop_v[i],  1'b0);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1, no parity
    send(2'd0, 8'hA5, "0101001011", 44);
    check_idle("after_a5");
    // even then odd parity
    send(2'd1, 8'h55, "01010101001", 48);
    send(2'd1, 8'h07, "01110000011", 48);
    send(2'd2, 8'h03, "01100000011", 48);
    send(2'd2, 8'h01, "01000000001", 48);
    // 7 data bits, 2 stop bits
    send(2'd3, 8'h7F, "0111111111", 44);
    send(2'd3, 8'h2A, "0010101011", 44);
    check_idle("after_7n2");

`ifndef UART_TX_FIFO_EN
    // tx_en held across a frame: only the end-of-frame offer is taken
    sel   = 2'd0;
    data  = 8'h11;
    tx_en = 1'b1;
    expect_frame("0100010001", cyc + 1);
    expect_frame("0010001001", cyc + 41);
    @(negedge clk);
    data = 8'h22;
    repeat (20) @(negedge clk);
    check("midframe ready", ready_v[0], 1'b0);
    repeat (20) @(negedge clk);
    tx_en = 1'b0;
    data  = 8'h00;
    repeat (44) @(negedge clk);
    check_idle("after_b2b");
`else
    // five pushes into a four-deep buffer
    sel   = 2'd0;
    t     = cyc;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: expect_frame("0100000001", t + 2);
        1: expect_frame("0010000001", t + 42);
        2: expect_frame("0001000001", t + 82);
        3: expect_frame("0000100001", t + 122);
        default: expect_frame("0000010001", t + 162);
      endcase
    end
    tx_en = 1'b1;
    data  = 8'h01;
    @(negedge clk); data = 8'h02;
    @(negedge clk); data = 8'h04;
    @(negedge clk); data = 8'h08;
    @(negedge clk);
    check("fifo full ready", ready_v[0], 1'b0);
    data = 8'h10;
    while (cyc < t + 20) @(negedge clk);
    check("fifo still full", ready_v[0], 1'b0);
    while (cyc < t + 41) @(negedge clk);
    check("fifo ready on readout", ready_v[0], 1'b1);
    @(negedge clk);
    tx_en = 1'b0;
    data  = 8'h00;
    while (cyc < t + 206) @(negedge clk);
    check_idle("after_fifo");
`endif

    // reset on cycle 13 of a frame
    sel   = 2'd0;
    data  = 8'h00;
    tx_en = 1'b1;
    t     = cyc + 1 + LAT;
    expect_frame("0000000001", t);
    @(negedge clk);
    tx_en = 1'b0;
    while (cyc < t + 12) @(negedge clk);
    check("pre_reset line", out_v[0], 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("abort line",  out_v[0],   1'b1);
    check("abort busy",  busy_v[0],  1'b0);
    check("abort ready", ready_v[0], 1'b1);
    check("abort stop",  stop_v[0],  1'b0);
    rst = 1'b1;
    repeat (50) @(negedge clk);
    check_idle("after_abort");

    check("frames_outstanding", exp_q.size(), 0);
    check("frame_in_progress", active, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected end of stimulus");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
